// File: rtl/io_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | io_bus_arbiter: round-robin two-master arbiter/sequencer for the IO port.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module io_bus_arbiter #(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic [31:0] IO_mem_addr,
    output logic [31:0] IO_mem_wdata,
    output logic        IO_mem_wr,
    output logic        IO_mem_rd,
    input  logic [31:0] IO_mem_rdata,
    output logic        owner
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_WAIT  = 4'b0100,
        S_ACK   = 4'b1000
    } state_t;

    localparam logic [2:0] C_RD_LAT = 3'(RD_LATENCY);

    state_t      r_state, w_state_nxt;
    logic        r_owner, w_owner_nxt;
    logic        r_is_wr, w_is_wr_nxt;
    logic [2:0]  r_cnt, w_cnt_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic        r_wr, w_wr_nxt;
    logic        r_rd, w_rd_nxt;
    logic        r_ack0, w_ack0_nxt;
    logic        r_ack1, w_ack1_nxt;
    logic [31:0] r_rdata0, w_rdata0_nxt;
    logic [31:0] r_rdata1, w_rdata1_nxt;
    logic        w_pick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_owner  <= 1'b0;
            r_is_wr  <= 1'b0;
            r_cnt    <= 3'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_wr     <= 1'b0;
            r_rd     <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= 32'h0;
            r_rdata1 <= 32'h0;
        end else begin
            r_state  <= w_state_nxt;
            r_owner  <= w_owner_nxt;
            r_is_wr  <= w_is_wr_nxt;
            r_cnt    <= w_cnt_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wr     <= w_wr_nxt;
            r_rd     <= w_rd_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
        end
    end

    // Strobes and acks are computed one cycle ahead so every output is a flop.
    always_comb begin
        w_state_nxt  = r_state;
        w_owner_nxt  = r_owner;
        w_is_wr_nxt  = r_is_wr;
        w_cnt_nxt    = r_cnt;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_wr_nxt     = 1'b0;
        w_rd_nxt     = 1'b0;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_pick       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    // On contention the master that did not win last time goes next.
                    w_pick      = (m0_req && m1_req) ? ~r_owner : m1_req;
                    w_owner_nxt = w_pick;
                    w_addr_nxt  = w_pick ? m1_addr  : m0_addr;
                    w_wdata_nxt = w_pick ? m1_wdata : m0_wdata;
                    w_is_wr_nxt = w_pick ? m1_wr    : m0_wr;
                    w_wr_nxt    = w_is_wr_nxt;
                    w_rd_nxt    = ~w_is_wr_nxt;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_is_wr) begin
                    w_ack0_nxt  = ~r_owner;
                    w_ack1_nxt  = r_owner;
                    w_state_nxt = S_ACK;
                end else begin
                    w_cnt_nxt   = C_RD_LAT;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    if (r_owner) w_rdata1_nxt = IO_mem_rdata;
                    else         w_rdata0_nxt = IO_mem_rdata;
                    w_ack0_nxt  = ~r_owner;
                    w_ack1_nxt  = r_owner;
                    w_state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign m0_ack       = r_ack0;
    assign m1_ack       = r_ack1;
    assign m0_rdata     = r_rdata0;
    assign m1_rdata     = r_rdata1;
    assign IO_mem_addr  = r_addr;
    assign IO_mem_wdata = r_wdata;
    assign IO_mem_wr    = r_wr;
    assign IO_mem_rd    = r_rd;
    assign owner        = r_owner;

endmodule
`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_io_bus_arbiter: directed self-checking bench for io_bus_arbiter.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_io_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_wr, m1_req, m1_wr, d3_m1_req;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_rdata;

    logic        m0_ack, m1_ack, bus_wr, bus_rd, owner;
    logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata;

    logic        d3_m0_ack, d3_m1_ack, d3_bus_wr, d3_bus_rd, d3_owner;
    logic [31:0] d3_m0_rdata, d3_m1_rdata, d3_bus_addr, d3_bus_wdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    io_bus_arbiter #(.RD_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .IO_mem_addr(bus_addr), .IO_mem_wdata(bus_wdata), .IO_mem_wr(bus_wr),
        .IO_mem_rd(bus_rd), .IO_mem_rdata(bus_rdata), .owner(owner)
    );

    // Second instance exercises a longer read latency; only master 1 is driven.
    io_bus_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .m0_req(1'b0), .m0_wr(1'b0), .m0_addr(32'h0), .m0_wdata(32'h0),
        .m0_ack(d3_m0_ack), .m0_rdata(d3_m0_rdata),
        .m1_req(d3_m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d3_m1_ack), .m1_rdata(d3_m1_rdata),
        .IO_mem_addr(d3_bus_addr), .IO_mem_wdata(d3_bus_wdata), .IO_mem_wr(d3_bus_wr),
        .IO_mem_rd(d3_bus_rd), .IO_mem_rdata(bus_rdata), .owner(d3_owner)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
        d3_m1_req = 0; bus_rdata = 0;
        #2;
        n_cmp++;
        if ({m0_ack, m1_ack, bus_wr, bus_rd, owner} !== 5'b0) begin
            n_err++; $display("FAIL reset_ctrl: got %b required 00000", {m0_ack, m1_ack, bus_wr, bus_rd, owner});
        end
        n_cmp++;
        if ({bus_addr, bus_wdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_bus: got addr %h wdata %h required 0", bus_addr, bus_wdata);
        end
        n_cmp++;
        if ({m0_rdata, m1_rdata} !== 64'h0) begin
            n_err++; $display("FAIL reset_rdata: got %h %h required 0", m0_rdata, m1_rdata);
        end
        tick; tick;
        reset = 1'b0;
        tick;
        n_cmp++;
        if ({m0_ack, m1_ack, bus_wr, bus_rd} !== 4'b0) begin
            n_err++; $display("FAIL idle_quiet: got %b required 0000", {m0_ack, m1_ack, bus_wr, bus_rd});
        end
    endtask

    task automatic test_single_write;
        m0_req = 1; m0_wr = 1; m0_addr = 32'h0040_0004; m0_wdata = 32'h0000_00AB;
        for (int c = 1; c <= 3; c++) begin
            tick;
            n_cmp++;
            if (bus_wr !== (c == 1) || bus_rd !== 1'b0) begin
                n_err++; $display("FAIL wr_strobe c%0d: got wr %b rd %b required wr %b rd 0", c, bus_wr, bus_rd, c == 1);
            end
            n_cmp++;
            if (m0_ack !== (c == 2) || m1_ack !== 1'b0) begin
                n_err++; $display("FAIL wr_ack c%0d: got m0 %b m1 %b required m0 %b m1 0", c, m0_ack, m1_ack, c == 2);
            end
            if (c == 1) begin
                n_cmp++;
                if (bus_addr !== 32'h0040_0004 || bus_wdata !== 32'h0000_00AB || owner !== 1'b0) begin
                    n_err++; $display("FAIL wr_fields: got %h %h own %b required 00400004 000000ab own 0", bus_addr, bus_wdata, owner);
                end
            end
            if (c == 2) m0_req = 0;
        end
    endtask

    task automatic test_read_lat1;
        bus_rdata = 32'hDEAD_BEEF;
        m1_req = 1; m1_wr = 0; m1_addr = 32'h0040_0008;
        for (int c = 1; c <= 4; c++) begin
            tick;
            bus_rdata = (c == 2) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            n_cmp++;
            if (bus_rd !== (c == 1) || bus_wr !== 1'b0) begin
                n_err++; $display("FAIL rd1_strobe c%0d: got rd %b wr %b required rd %b wr 0", c, bus_rd, bus_wr, c == 1);
            end
            n_cmp++;
            if (m1_ack !== (c == 3) || m0_ack !== 1'b0) begin
                n_err++; $display("FAIL rd1_ack c%0d: got m1 %b m0 %b required m1 %b m0 0", c, m1_ack, m0_ack, c == 3);
            end
            if (c == 1) begin
                n_cmp++;
                if (bus_addr !== 32'h0040_0008 || owner !== 1'b1) begin
                    n_err++; $display("FAIL rd1_addr: got %h own %b required 00400008 own 1", bus_addr, owner);
                end
            end
            if (c >= 3) begin
                n_cmp++;
                if (m1_rdata !== 32'h1234_5678) begin
                    n_err++; $display("FAIL rd1_data c%0d: got %h required 12345678", c, m1_rdata);
                end
            end
            if (c == 3) m1_req = 0;
        end
    endtask

    task automatic test_read_lat3;
        bus_rdata = 32'hDEAD_BEEF;
        d3_m1_req = 1; m1_wr = 0; m1_addr = 32'h0040_0008;
        for (int c = 1; c <= 6; c++) begin
            tick;
            bus_rdata = (c == 4) ? 32'h1234_5678 : 32'hDEAD_BEEF;
            n_cmp++;
            if (d3_bus_rd !== (c == 1)) begin
                n_err++; $display("FAIL rd3_strobe c%0d: got %b required %b", c, d3_bus_rd, c == 1);
            end
            n_cmp++;
            if (d3_m1_ack !== (c == 5)) begin
                n_err++; $display("FAIL rd3_ack c%0d: got %b required %b", c, d3_m1_ack, c == 5);
            end
            if (c == 1) begin
                n_cmp++;
                if (d3_bus_addr !== 32'h0040_0008) begin
                    n_err++; $display("FAIL rd3_addr: got %h required 00400008", d3_bus_addr);
                end
            end
            if (c >= 5) begin
                n_cmp++;
                if (d3_m1_rdata !== 32'h1234_5678) begin
                    n_err++; $display("FAIL rd3_data c%0d: got %h required 12345678", c, d3_m1_rdata);
                end
            end
            if (c == 5) d3_m1_req = 0;
        end
    endtask

    task automatic test_contention;
        logic [31:0] exp_addr;
        reset = 1;
        tick;
        reset = 0;
        m0_req = 1; m0_wr = 1; m0_addr = 32'h0040_0100; m0_wdata = 32'h0000_0A0A;
        m1_req = 1; m1_wr = 1; m1_addr = 32'h0040_0200; m1_wdata = 32'h0000_0B0B;
        for (int c = 1; c <= 12; c++) begin
            tick;
            n_cmp++;
            if (m1_ack !== (c == 2 || c == 8) || m0_ack !== (c == 5 || c == 11)) begin
                n_err++; $display("FAIL cont_ack c%0d: got m0 %b m1 %b required m0 %b m1 %b",
                                  c, m0_ack, m1_ack, c == 5 || c == 11, c == 2 || c == 8);
            end
            n_cmp++;
            if (bus_wr !== (c % 3 == 1 && c < 12)) begin
                n_err++; $display("FAIL cont_wr c%0d: got %b required %b", c, bus_wr, c % 3 == 1 && c < 12);
            end
            if (c % 3 == 1 && c < 12) begin
                exp_addr = (c == 1 || c == 7) ? 32'h0040_0200 : 32'h0040_0100;
                n_cmp++;
                if (bus_addr !== exp_addr || owner !== (c == 1 || c == 7)) begin
                    n_err++; $display("FAIL cont_grant c%0d: got %h own %b required %h own %b",
                                      c, bus_addr, owner, exp_addr, c == 1 || c == 7);
                end
            end
            if (c == 11) begin
                m0_req = 0; m1_req = 0;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] addrs [3];
        addrs[0] = 32'h0040_0010; addrs[1] = 32'h0040_0014; addrs[2] = 32'h0040_0018;
        bus_rdata = 32'h1000_0000;
        m0_req = 1; m0_wr = 0; m0_addr = addrs[0];
        for (int c = 1; c <= 12; c++) begin
            tick;
            bus_rdata = 32'h1000_0000 + 32'(c);
            n_cmp++;
            if (bus_rd !== (c == 1 || c == 5 || c == 9)) begin
                n_err++; $display("FAIL b2b_rd c%0d: got %b required %b", c, bus_rd, c == 1 || c == 5 || c == 9);
            end
            if (c == 1 || c == 5 || c == 9) begin
                n_cmp++;
                if (bus_addr !== addrs[(c - 1) / 4]) begin
                    n_err++; $display("FAIL b2b_addr c%0d: got %h required %h", c, bus_addr, addrs[(c - 1) / 4]);
                end
            end
            n_cmp++;
            if (m0_ack !== (c == 3 || c == 7 || c == 11)) begin
                n_err++; $display("FAIL b2b_ack c%0d: got %b required %b", c, m0_ack, c == 3 || c == 7 || c == 11);
            end
            if (c == 3 || c == 7 || c == 11) begin
                n_cmp++;
                if (m0_rdata !== 32'h1000_0000 + 32'(c - 1)) begin
                    n_err++; $display("FAIL b2b_data c%0d: got %h required %h", c, m0_rdata, 32'h1000_0000 + 32'(c - 1));
                end
                if (c == 11) m0_req = 0;
                else         m0_addr = addrs[(c + 1) / 4];
            end
        end
    endtask

    task automatic test_field_change;
        m0_req = 1; m0_wr = 0; m0_addr = 32'h0040_0010;
        for (int c = 1; c <= 4; c++) begin
            tick;
            n_cmp++;
            if (bus_addr !== 32'h0040_0010) begin
                n_err++; $display("FAIL hold_addr c%0d: got %h required 00400010", c, bus_addr);
            end
            if (c == 1) m0_addr = 32'h0040_0099;
            if (c == 2) begin
                m0_addr = 32'h0040_00AA; m0_wr = 1;
            end
            if (c == 3) begin
                n_cmp++;
                if (m0_ack !== 1'b1) begin
                    n_err++; $display("FAIL hold_ack: got %b required 1", m0_ack);
                end
                m0_req = 0; m0_wr = 0;
            end
        end
    endtask

    task automatic test_reset_mid_read;
        m0_req = 1; m0_wr = 0; m0_addr = 32'h0040_0020;
        tick; tick;
        #2 reset = 1;
        #1;
        n_cmp++;
        if ({m0_ack, m1_ack, bus_wr, bus_rd, owner} !== 5'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            n_err++; $display("FAIL mid_rst_out: got ctl %b addr %h wdata %h required 0",
                              {m0_ack, m1_ack, bus_wr, bus_rd, owner}, bus_addr, bus_wdata);
        end
        n_cmp++;
        if (m0_rdata !== 32'h0 || m1_rdata !== 32'h0) begin
            n_err++; $display("FAIL mid_rst_rdata: got %h %h required 0", m0_rdata, m1_rdata);
        end
        n_cmp++;
        if ({d3_m0_ack, d3_m1_ack, d3_bus_wr, d3_bus_rd, d3_owner} !== 5'b0 ||
            (d3_m0_rdata | d3_m1_rdata | d3_bus_addr | d3_bus_wdata) !== 32'h0) begin
            n_err++; $display("FAIL mid_rst_d3: got ctl %b rdata %h required 0",
                              {d3_m0_ack, d3_m1_ack, d3_bus_wr, d3_bus_rd, d3_owner}, d3_m1_rdata);
        end
        tick;
        n_cmp++;
        if (m0_ack !== 1'b0) begin
            n_err++; $display("FAIL mid_rst_noack: got %b required 0", m0_ack);
        end
        tick;
        reset = 0;
        bus_rdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            tick;
            bus_rdata = (c == 2) ? 32'hCAFE_F00D : 32'h0;
            n_cmp++;
            if (bus_rd !== (c == 1) || m0_ack !== (c == 3)) begin
                n_err++; $display("FAIL post_rst c%0d: got rd %b ack %b required rd %b ack %b", c, bus_rd, m0_ack, c == 1, c == 3);
            end
            if (c == 3) begin
                n_cmp++;
                if (m0_rdata !== 32'hCAFE_F00D) begin
                    n_err++; $display("FAIL post_rst_data: got %h required cafef00d", m0_rdata);
                end
                m0_req = 0;
            end
        end
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_read_lat1;
        test_read_lat3;
        test_contention;
        test_back_to_back;
        test_field_change;
        test_reset_mid_read;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
